// File: rtl/word_serializer_pkg.sv
// Shared types and defaults for the word serializer slice.
package word_serializer_pkg;

  localparam int DEFAULT_WIDTH = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

endpackage

// File: rtl/word_serializer_if.sv
// Parallel-in / serial-out handshake bundle between upstream, serializer and consumer.
interface word_serializer_if
  import word_serializer_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
);

  logic [WIDTH-1:0] I;
  logic             load;
  logic             hold;
  logic             ready;
  logic             so;
  logic             so_valid;
  logic             done;

  modport master (
    output I, load, hold,
    input  ready, so, so_valid, done
  );

  modport slave (
    input  I, load, hold,
    output ready, so, so_valid, done
  );

endinterface

// File: rtl/ws_shift_reg.sv
// Loadable shift register that moves data toward a head bit and zero-fills the tail.
module ws_shift_reg
  import word_serializer_pkg::*;
#(
  parameter int WIDTH     = DEFAULT_WIDTH,
  parameter bit LSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             clr_n,
  input  logic             ld,
  input  logic             en,
  input  logic [WIDTH-1:0] d,
  output logic             head
);

  logic [WIDTH-1:0] q;
  logic [WIDTH-1:0] q_shifted;

  // The head sits at bit 0 for LSB-first, bit WIDTH-1 otherwise.
  generate
    if (LSB_FIRST) begin : g_lsb
      assign q_shifted = {1'b0, q[WIDTH-1:1]};
      assign head      = q[0];
    end else begin : g_msb
      assign q_shifted = {q[WIDTH-2:0], 1'b0};
      assign head      = q[WIDTH-1];
    end
  endgenerate

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      q <= '0;
    end else if (ld) begin
      q <= d;
    end else if (en) begin
      q <= q_shifted;
    end
  end

endmodule

// File: rtl/word_serializer.sv
// Serializes one WIDTH-bit word per load, with downstream stall and a done pulse.
module word_serializer
  import word_serializer_pkg::*;
#(
  parameter int WIDTH     = DEFAULT_WIDTH,
  parameter bit LSB_FIRST = 1'b1
) (
  input  logic               clk,
  input  logic               clr_n,
  word_serializer_if.slave   bus
);

  localparam int CW = $clog2(WIDTH);

  state_t          state;
  state_t          state_next;
  logic [CW-1:0]   cnt;
  logic            accept;
  logic            advance;
  logic            last_bit;
  logic            head;
  logic            ready_q;

  assign last_bit  = (cnt == CW'(WIDTH - 1));
  assign bus.ready = ready_q;

  ws_shift_reg #(
    .WIDTH     (WIDTH),
    .LSB_FIRST (LSB_FIRST)
  ) u_shift (
    .clk   (clk),
    .clr_n (clr_n),
    .ld    (accept),
    .en    (advance),
    .d     (bus.I),
    .head  (head)
  );

  // ready is registered from the next state so it stays low through reset.
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      state   <= IDLE;
      ready_q <= 1'b0;
    end else begin
      state   <= state_next;
      ready_q <= (state_next == IDLE);
    end
  end

  // The counter stops at WIDTH-1 on the last bit so it never wraps within a word.
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      cnt <= '0;
    end else if (accept) begin
      cnt <= '0;
    end else if (advance && !last_bit) begin
      cnt <= cnt + CW'(1);
    end
  end

  always_comb begin
    state_next   = state;
    accept       = 1'b0;
    advance      = 1'b0;
    bus.so       = 1'b0;
    bus.so_valid = 1'b0;
    bus.done     = 1'b0;
    case (state)
      IDLE: begin
        if (bus.load) begin
          accept     = 1'b1;
          state_next = SHIFT;
        end
      end
      SHIFT: begin
        bus.so       = head;
        bus.so_valid = ~bus.hold;
        if (!bus.hold) begin
          advance = 1'b1;
          if (last_bit) begin
            state_next = DONE;
          end
        end
      end
      DONE: begin
        bus.done   = 1'b1;
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_word_serializer.sv
// Directed bench for word_serializer: one LSB-first and one MSB-first instance.
module tb_word_serializer;

  logic clk;
  logic clr_n;
  int   vectors;
  int   miscompares;

  word_serializer_if #(.WIDTH(4)) bus0 ();
  word_serializer_if #(.WIDTH(4)) bus1 ();

  word_serializer #(.WIDTH(4), .LSB_FIRST(1'b1)) dut0 (
    .clk   (clk),
    .clr_n (clr_n),
    .bus   (bus0)
  );

  word_serializer #(.WIDTH(4), .LSB_FIRST(1'b0)) dut1 (
    .clk   (clk),
    .clr_n (clr_n),
    .bus   (bus1)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    clr_n = 1'b0;
    #3;
    vectors++; if (bus0.ready !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_ready got %b want 0", bus0.ready); end
    vectors++; if (bus0.so !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_so got %b want 0", bus0.so); end
    vectors++; if (bus0.so_valid !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_so_valid got %b want 0", bus0.so_valid); end
    vectors++; if (bus0.done !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_done got %b want 0", bus0.done); end
    @(negedge clk);
    clr_n = 1'b1;
    tick();
    #1;
    vectors++; if (bus0.ready !== 1'b1) begin miscompares++; $display("[TB] FAIL reset_release_ready got %b want 1", bus0.ready); end
    vectors++; if (bus1.ready !== 1'b1) begin miscompares++; $display("[TB] FAIL reset_release_ready1 got %b want 1", bus1.ready); end
  endtask

  task automatic test_lsb_first;
    logic [0:3] seq;
    seq = 4'b0101;
    bus0.I    = 4'b1010;
    bus0.load = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      bus0.load = 1'b0;
      #1;
      vectors++; if (bus0.so !== seq[i]) begin miscompares++; $display("[TB] FAIL lsb_so bit %0d got %b want %b", i, bus0.so, seq[i]); end
      vectors++; if (bus0.so_valid !== 1'b1) begin miscompares++; $display("[TB] FAIL lsb_valid bit %0d got %b want 1", i, bus0.so_valid); end
      vectors++; if (bus0.ready !== 1'b0) begin miscompares++; $display("[TB] FAIL lsb_ready bit %0d got %b want 0", i, bus0.ready); end
    end
    tick(); #1;
    vectors++; if (bus0.done !== 1'b1) begin miscompares++; $display("[TB] FAIL lsb_done got %b want 1", bus0.done); end
    vectors++; if (bus0.so_valid !== 1'b0) begin miscompares++; $display("[TB] FAIL lsb_done_valid got %b want 0", bus0.so_valid); end
    vectors++; if (bus0.ready !== 1'b0) begin miscompares++; $display("[TB] FAIL lsb_done_ready got %b want 0", bus0.ready); end
    tick(); #1;
    vectors++; if (bus0.ready !== 1'b1) begin miscompares++; $display("[TB] FAIL lsb_ready_after got %b want 1", bus0.ready); end
    vectors++; if (bus0.done !== 1'b0) begin miscompares++; $display("[TB] FAIL lsb_done_after got %b want 0", bus0.done); end
  endtask

  task automatic test_msb_first;
    logic [0:3] seq;
    seq = 4'b1100;
    bus1.I    = 4'b1100;
    bus1.load = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      bus1.load = 1'b0;
      #1;
      vectors++; if (bus1.so !== seq[i]) begin miscompares++; $display("[TB] FAIL msb_so bit %0d got %b want %b", i, bus1.so, seq[i]); end
      vectors++; if (bus1.so_valid !== 1'b1) begin miscompares++; $display("[TB] FAIL msb_valid bit %0d got %b want 1", i, bus1.so_valid); end
    end
    tick(); #1;
    vectors++; if (bus1.done !== 1'b1) begin miscompares++; $display("[TB] FAIL msb_done got %b want 1", bus1.done); end
    tick(); #1;
    vectors++; if (bus1.ready !== 1'b1) begin miscompares++; $display("[TB] FAIL msb_ready_after got %b want 1", bus1.ready); end
  endtask

  task automatic test_hold;
    bus0.I    = 4'b0110;
    bus0.load = 1'b1;
    tick();
    bus0.load = 1'b0;
    #1;
    vectors++; if (bus0.so !== 1'b0 || bus0.so_valid !== 1'b1) begin miscompares++; $display("[TB] FAIL hold_bit0 got so=%b v=%b want so=0 v=1", bus0.so, bus0.so_valid); end
    for (int i = 0; i < 2; i++) begin
      tick();
      bus0.hold = 1'b1;
      #1;
      vectors++; if (bus0.so !== 1'b1 || bus0.so_valid !== 1'b0) begin miscompares++; $display("[TB] FAIL hold_stall %0d got so=%b v=%b want so=1 v=0", i, bus0.so, bus0.so_valid); end
      vectors++; if (bus0.ready !== 1'b0) begin miscompares++; $display("[TB] FAIL hold_ready %0d got %b want 0", i, bus0.ready); end
    end
    tick();
    bus0.hold = 1'b0;
    #1;
    vectors++; if (bus0.so !== 1'b1 || bus0.so_valid !== 1'b1) begin miscompares++; $display("[TB] FAIL hold_bit1 got so=%b v=%b want so=1 v=1", bus0.so, bus0.so_valid); end
    tick(); #1;
    vectors++; if (bus0.so !== 1'b1 || bus0.so_valid !== 1'b1) begin miscompares++; $display("[TB] FAIL hold_bit2 got so=%b v=%b want so=1 v=1", bus0.so, bus0.so_valid); end
    vectors++; if (bus0.done !== 1'b0) begin miscompares++; $display("[TB] FAIL hold_early_done got %b want 0", bus0.done); end
    tick(); #1;
    vectors++; if (bus0.so !== 1'b0 || bus0.so_valid !== 1'b1) begin miscompares++; $display("[TB] FAIL hold_bit3 got so=%b v=%b want so=0 v=1", bus0.so, bus0.so_valid); end
    tick();
    bus0.hold = 1'b1;
    #1;
    vectors++; if (bus0.done !== 1'b1) begin miscompares++; $display("[TB] FAIL hold_done got %b want 1", bus0.done); end
    tick();
    bus0.hold = 1'b0;
    #1;
    vectors++; if (bus0.ready !== 1'b1) begin miscompares++; $display("[TB] FAIL hold_ready_after got %b want 1", bus0.ready); end
  endtask

  task automatic test_ignore_load;
    logic [0:3] seq;
    seq = 4'b1000;
    bus0.I    = 4'b0001;
    bus0.load = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      bus0.I    = 4'b1111;
      bus0.load = 1'b1;
      #1;
      vectors++; if (bus0.so !== seq[i]) begin miscompares++; $display("[TB] FAIL ign_so bit %0d got %b want %b", i, bus0.so, seq[i]); end
      vectors++; if (bus0.ready !== 1'b0) begin miscompares++; $display("[TB] FAIL ign_ready bit %0d got %b want 0", i, bus0.ready); end
    end
    tick();
    bus0.load = 1'b0;
    bus0.I    = 4'b0000;
    #1;
    vectors++; if (bus0.done !== 1'b1) begin miscompares++; $display("[TB] FAIL ign_done got %b want 1", bus0.done); end
    tick(); #1;
    vectors++; if (bus0.ready !== 1'b1) begin miscompares++; $display("[TB] FAIL ign_ready_after got %b want 1", bus0.ready); end
    tick(); #1;
    vectors++; if (bus0.so_valid !== 1'b0 || bus0.ready !== 1'b1) begin miscompares++; $display("[TB] FAIL ign_idle got v=%b rdy=%b want v=0 rdy=1", bus0.so_valid, bus0.ready); end
  endtask

  task automatic test_reset_mid;
    logic [0:2] seq;
    seq = 3'b110;
    bus0.I    = 4'b1011;
    bus0.load = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      bus0.load = 1'b0;
      #1;
      vectors++; if (bus0.so !== seq[i] || bus0.so_valid !== 1'b1) begin miscompares++; $display("[TB] FAIL rmid_bit %0d got so=%b v=%b want so=%b v=1", i, bus0.so, bus0.so_valid, seq[i]); end
    end
    clr_n = 1'b0;
    #1;
    vectors++; if (bus0.so_valid !== 1'b0) begin miscompares++; $display("[TB] FAIL rmid_valid got %b want 0", bus0.so_valid); end
    vectors++; if (bus0.so !== 1'b0 || bus0.done !== 1'b0 || bus0.ready !== 1'b0) begin miscompares++; $display("[TB] FAIL rmid_outs got so=%b done=%b rdy=%b want 0 0 0", bus0.so, bus0.done, bus0.ready); end
    #1;
    clr_n = 1'b1;
    tick(); #1;
    vectors++; if (bus0.ready !== 1'b1) begin miscompares++; $display("[TB] FAIL rmid_ready got %b want 1", bus0.ready); end
    for (int i = 0; i < 5; i++) begin
      vectors++; if (bus0.done !== 1'b0 || bus0.so_valid !== 1'b0) begin miscompares++; $display("[TB] FAIL rmid_quiet %0d got done=%b v=%b want 0 0", i, bus0.done, bus0.so_valid); end
      tick(); #1;
    end
  endtask

  task automatic test_back_to_back;
    logic [0:3] seq_a;
    logic [0:3] seq_b;
    seq_a = 4'b1100;
    seq_b = 4'b1010;
    bus0.I    = 4'b0011;
    bus0.load = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick(); #1;
      vectors++; if (bus0.so !== seq_a[i] || bus0.so_valid !== 1'b1) begin miscompares++; $display("[TB] FAIL b2b_a bit %0d got so=%b v=%b want so=%b v=1", i, bus0.so, bus0.so_valid, seq_a[i]); end
    end
    tick();
    bus0.I = 4'b0101;
    #1;
    vectors++; if (bus0.done !== 1'b1) begin miscompares++; $display("[TB] FAIL b2b_done_a got %b want 1", bus0.done); end
    tick(); #1;
    vectors++; if (bus0.ready !== 1'b1 || bus0.so_valid !== 1'b0) begin miscompares++; $display("[TB] FAIL b2b_gap got rdy=%b v=%b want rdy=1 v=0", bus0.ready, bus0.so_valid); end
    for (int i = 0; i < 4; i++) begin
      tick();
      bus0.load = 1'b0;
      #1;
      vectors++; if (bus0.so !== seq_b[i] || bus0.so_valid !== 1'b1) begin miscompares++; $display("[TB] FAIL b2b_b bit %0d got so=%b v=%b want so=%b v=1", i, bus0.so, bus0.so_valid, seq_b[i]); end
    end
    tick(); #1;
    vectors++; if (bus0.done !== 1'b1) begin miscompares++; $display("[TB] FAIL b2b_done_b got %b want 1", bus0.done); end
    tick(); #1;
    vectors++; if (bus0.ready !== 1'b1) begin miscompares++; $display("[TB] FAIL b2b_ready_after got %b want 1", bus0.ready); end
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    clr_n       = 1'b0;
    bus0.I      = '0;
    bus0.load   = 1'b0;
    bus0.hold   = 1'b0;
    bus1.I      = '0;
    bus1.load   = 1'b0;
    bus1.hold   = 1'b0;
    tick();
    test_reset();
    test_lsb_first();
    test_msb_first();
    test_hold();
    test_ignore_load();
    test_reset_mid();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/word_serializer.md
WORD_SERIALIZER -- requirements
Module: word_serializer

Interface
REQ-001 SHALL have parameter WIDTH, default 4, word width in bits (legal range 2..16).
REQ-002 SHALL have parameter LSB_FIRST, default 1: 1 = shift out bit 0 first; 0 = shift out bit WIDTH-1 first.
REQ-003 SHALL have port: clk  input  1  single clock; all state updates on posedge.
REQ-004 SHALL have port: clr_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port: I  input  WIDTH  parallel word taken from the upstream load/clear register output A.
REQ-006 SHALL have port: load  input  1  word-valid request from upstream.
REQ-007 SHALL have port: hold  input  1  stall request from the downstream serial consumer.
REQ-008 SHALL have port: ready  output  1  high when a word can be accepted.
REQ-009 SHALL have port: so  output  1  serial data bit.
REQ-010 SHALL have port: so_valid  output  1  so carries a valid bit this cycle.
REQ-011 SHALL have port: done  output  1  one-cycle pulse after the last bit.

Function
REQ-012 SHALL implement FSM states IDLE, SHIFT, DONE.
REQ-013 SHALL assert ready only in IDLE. ready SHALL be a registered state decode, not combinational on load.
REQ-014 In IDLE, when load=1 at a posedge:
- I SHALL be captured into the shift register.
- The bit counter SHALL clear to 0.
- The FSM SHALL enter SHIFT.
REQ-015 In IDLE with load=0, the FSM SHALL remain in IDLE. so=0, so_valid=0.
REQ-016 In SHIFT, so SHALL equal the current head bit (bit 0 if LSB_FIRST, else bit WIDTH-1).
REQ-017 In SHIFT, so_valid SHALL equal ~hold.
REQ-018 In SHIFT with hold=0, each posedge SHALL:
- shift the register one place toward the head, zero-filling the tail;
- increment the counter.
REQ-019 In SHIFT with hold=1, the shift register, counter and state SHALL all be frozen. so SHALL keep its value.
REQ-020 When the counter equals WIDTH-1 and hold=0, the next state SHALL be DONE.
REQ-021 DONE SHALL last exactly one cycle, then return to IDLE. In DONE: done=1, ready=0, so_valid=0, so=0. hold SHALL be ignored.
REQ-022 Latency with hold never asserted, load accepted at edge k:
- bit n SHALL be on so during cycle k+1+n, for n = 0..WIDTH-1;
- done SHALL be high during cycle k+WIDTH+1;
- ready SHALL be high again from cycle k+WIDTH+2.
REQ-023 load SHALL be ignored outside IDLE. Upstream SHALL hold I stable only during the accepting cycle.
REQ-024 The counter SHALL be ceil(log2(WIDTH)) bits wide. It SHALL never wrap inside a word.

Reset
REQ-025 clr_n=0 SHALL immediately force all of the following, regardless of clk:
- state=IDLE;
- shift register=0 and counter=0;
- so=0, so_valid=0, done=0.
REQ-026 ready SHALL be 0 while clr_n=0. It SHALL be 1 in the first cycle after clr_n rises.
REQ-027 Reset mid-SHIFT or mid-DONE SHALL discard the word. No done pulse SHALL be produced for that word.

Structure
REQ-028 Package word_serializer_pkg SHALL hold the state enum (IDLE, SHIFT, DONE) and the default WIDTH constant.
REQ-029 The shift register SHALL be a sub-module ws_shift_reg, with ports:
- clk, clr_n;
- ld, en, d[WIDTH], head.
REQ-030 The FSM and counter SHALL live in word_serializer.

Verification
REQ-031 Reset, then I=4'b1010 with load=1 for one cycle -> so=0,1,0,1 in cycles 1-4 with so_valid=1; done=1 in cycle 5; ready=1 in cycle 6.
REQ-032 LSB_FIRST=0, I=4'b1100 -> so=1,1,0,0.
REQ-033 I=4'b0110 with hold=1 for 2 cycles during bit 1 -> so_valid=0 for those 2 cycles; so stays 1; done is delayed by exactly 2 cycles.
REQ-034 Second load=1 with I=4'b1111 during SHIFT of 4'b0001 -> ignored; output is 1,0,0,0 only; ready=0 throughout.
REQ-035 clr_n pulsed low during bit 2 of 4'b1011 -> so=0, so_valid=0, done=0 immediately; no done pulse follows; ready=1 one cycle after release.
REQ-036 Back-to-back words 4'b0011 then 4'b0101, each with load held high -> second word accepted in the first ready cycle after done; the gap between words is exactly 1 cycle (DONE) plus 1 cycle (IDLE).
